// File: rtl/median_filter_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : median_filter_regs_pkg
//  Description : Shared constants and types for the median filter AXI4-Lite
//                register slave. Holds the register word indices, CTRL and
//                STATUS bit positions, AXI response codes, register reset
//                values, the kernel-size enum and a byte-strobe merge helper.
//  Revision    : 2.0 - typed register map with status, version and irq
// ============================================================================
package median_filter_regs_pkg;

    // Register word indices
    localparam logic [2:0] c_reg_ctrl     = 3'd0;
    localparam logic [2:0] c_reg_status   = 3'd1;
    localparam logic [2:0] c_reg_width    = 3'd2;
    localparam logic [2:0] c_reg_height   = 3'd3;
    localparam logic [2:0] c_reg_ksize    = 3'd4;
    localparam logic [2:0] c_reg_pix_cnt  = 3'd5;
    localparam logic [2:0] c_reg_version  = 3'd6;
    localparam logic [2:0] c_reg_scratch  = 3'd7;

    // CTRL bit positions
    localparam int c_ctrl_start    = 0;
    localparam int c_ctrl_irq_en   = 1;
    localparam int c_ctrl_soft_rst = 2;

    // STATUS bit positions
    localparam int c_stat_busy = 0;
    localparam int c_stat_done = 1;

    // AXI response codes
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    // Register reset values
    localparam logic [15:0] c_rst_width   = 16'd640;
    localparam logic [15:0] c_rst_height  = 16'd480;
    localparam logic [31:0] c_rst_scratch = 32'h0000_0000;

    typedef enum logic [1:0] {
        KSIZE_3X3   = 2'd0,
        KSIZE_5X5   = 2'd1,
        KSIZE_RSVD2 = 2'd2,
        KSIZE_RSVD3 = 2'd3
    } ksize_e;

    // Replace the bytes of old_val whose strobe is set with the new data
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/median_filter_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module      : median_filter_axil_regs
//  Description : AXI4-Lite control/status register slave for the median
//                filter core. Eight word registers: CTRL (start/soft-reset
//                pulses, irq enable), STATUS (busy, sticky W1C done),
//                image width/height, kernel size, pixel count, version and
//                scratch. Indices >= 8 answer SLVERR.
//  Ports       : S_AXI_*        AXI4-Lite slave (clock, async low reset)
//                start_pulse    one-cycle frame start to core
//                soft_rst_pulse one-cycle core soft reset
//                img_width/img_height/ksize  frame configuration
//                irq            level interrupt (IRQ_EN & DONE, registered)
//                core_busy/core_done/pix_cnt  core status inputs
//  Revision    : 2.0 - typed register map with status, version and irq
// ============================================================================
module median_filter_axil_regs
    import median_filter_regs_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] VERSION            = 32'h0002_0000
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            start_pulse,
    output logic                            soft_rst_pulse,
    output logic [15:0]                     img_width,
    output logic [15:0]                     img_height,
    output logic [1:0]                      ksize,
    output logic                            irq,
    input  logic                            core_busy,
    input  logic                            core_done,
    input  logic [31:0]                     pix_cnt
);

    localparam int c_aw    = C_S_AXI_ADDR_WIDTH;
    localparam int c_idx_w = C_S_AXI_ADDR_WIDTH - 2;

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
        $error("median_filter_axil_regs: C_S_AXI_DATA_WIDTH must be 32");
    end
    if (C_S_AXI_ADDR_WIDTH < 5) begin : g_bad_addr_width
        $error("median_filter_axil_regs: C_S_AXI_ADDR_WIDTH must be >= 5");
    end

    // Channel state
    logic              r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]        r_bresp, r_rresp;
    logic [31:0]       r_rdata;
    logic              r_aw_held, r_w_held;
    logic [c_aw-1:0]   r_aw_addr;
    logic [31:0]       r_w_data;
    logic [3:0]        r_w_strb;

    // Register file
    logic              r_irq_en, r_done, r_irq, r_start, r_soft_rst;
    logic [15:0]       r_width, r_height;
    ksize_e            r_ksize;
    logic [31:0]       r_scratch;

    logic              w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_do_write;
    logic              w_aw_held_nxt, w_w_held_nxt, w_bvalid_nxt, w_rvalid_nxt;
    logic [c_aw-1:0]   w_wr_addr;
    logic [31:0]       w_wr_data;
    logic [3:0]        w_wr_strb;
    logic [c_idx_w-1:0] w_wr_idx, w_rd_idx;
    logic              w_wr_oor, w_rd_oor, w_wr_en, w_ctrl_wr, w_w1c;
    logic              w_start, w_soft;
    logic [31:0]       w_rd_data;
    logic              w_unused;

    assign w_aw_hs = S_AXI_AWVALID & r_awready;
    assign w_w_hs  = S_AXI_WVALID  & r_wready;
    assign w_b_hs  = r_bvalid & S_AXI_BREADY;
    assign w_ar_hs = S_AXI_ARVALID & r_arready;

    // A beat arriving this cycle is used directly so AW+W in one cycle
    // produces the register update and BVALID on the very next edge.
    assign w_wr_addr  = r_aw_held ? r_aw_addr : S_AXI_AWADDR;
    assign w_wr_data  = r_w_held  ? r_w_data  : S_AXI_WDATA;
    assign w_wr_strb  = r_w_held  ? r_w_strb  : S_AXI_WSTRB;
    assign w_do_write = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs) & ~r_bvalid;

    assign w_aw_held_nxt = (r_aw_held | w_aw_hs) & ~w_b_hs;
    assign w_w_held_nxt  = (r_w_held  | w_w_hs)  & ~w_b_hs;
    assign w_bvalid_nxt  = w_do_write | (r_bvalid & ~S_AXI_BREADY);
    assign w_rvalid_nxt  = w_ar_hs | (r_rvalid & ~S_AXI_RREADY);

    assign w_wr_idx = w_wr_addr[c_aw-1:2];
    assign w_rd_idx = S_AXI_ARADDR[c_aw-1:2];

    // Any index bit above the 8-slot map marks the access out of range
    if (c_idx_w > 3) begin : g_oor_wide
        assign w_wr_oor = |w_wr_idx[c_idx_w-1:3];
        assign w_rd_oor = |w_rd_idx[c_idx_w-1:3];
    end else begin : g_oor_none
        assign w_wr_oor = 1'b0;
        assign w_rd_oor = 1'b0;
    end

    assign w_wr_en   = w_do_write & ~w_wr_oor;
    assign w_ctrl_wr = w_wr_en & (w_wr_idx[2:0] == c_reg_ctrl) & w_wr_strb[0];
    assign w_soft    = w_ctrl_wr & w_wr_data[c_ctrl_soft_rst];
    // Soft reset wins over a simultaneous start; start is dropped while busy
    assign w_start   = w_ctrl_wr & w_wr_data[c_ctrl_start] & ~w_wr_data[c_ctrl_soft_rst]
                     & ~core_busy;
    assign w_w1c     = w_wr_en & (w_wr_idx[2:0] == c_reg_status) & w_wr_strb[0]
                     & w_wr_data[c_stat_done];

    always_comb begin
        w_rd_data = 32'h0;
        case (w_rd_idx[2:0])
            c_reg_ctrl:    w_rd_data[c_ctrl_irq_en] = r_irq_en;
            c_reg_status:  w_rd_data[1:0] = {r_done, core_busy};
            c_reg_width:   w_rd_data[15:0] = r_width;
            c_reg_height:  w_rd_data[15:0] = r_height;
            c_reg_ksize:   w_rd_data[1:0] = r_ksize;
            c_reg_pix_cnt: w_rd_data = pix_cnt;
            c_reg_version: w_rd_data = VERSION;
            c_reg_scratch: w_rd_data = r_scratch;
            default:       w_rd_data = 32'h0;
        endcase
    end

    // AXI channel handshakes
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_resp_okay;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_addr <= '0;
            r_w_data  <= 32'h0;
            r_w_strb  <= 4'h0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_resp_okay;
            r_rdata   <= 32'h0;
        end else begin
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_awready <= ~w_aw_held_nxt & ~w_bvalid_nxt;
            r_wready  <= ~w_w_held_nxt  & ~w_bvalid_nxt;
            r_arready <= ~w_rvalid_nxt;
            r_rvalid  <= w_rvalid_nxt;
            if (w_aw_hs) begin
                r_aw_addr <= S_AXI_AWADDR;
            end
            if (w_w_hs) begin
                r_w_data <= S_AXI_WDATA;
                r_w_strb <= S_AXI_WSTRB;
            end
            if (w_do_write) begin
                r_bresp <= w_wr_oor ? c_resp_slverr : c_resp_okay;
            end
            if (w_ar_hs) begin
                r_rdata <= w_rd_oor ? 32'h0 : w_rd_data;
                r_rresp <= w_rd_oor ? c_resp_slverr : c_resp_okay;
            end
        end
    end

    // Register file, pulses and interrupt
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_irq_en   <= 1'b0;
            r_done     <= 1'b0;
            r_irq      <= 1'b0;
            r_start    <= 1'b0;
            r_soft_rst <= 1'b0;
            r_width    <= c_rst_width;
            r_height   <= c_rst_height;
            r_ksize    <= KSIZE_3X3;
            r_scratch  <= c_rst_scratch;
        end else begin
            r_start    <= w_start;
            r_soft_rst <= w_soft;
            r_irq      <= r_irq_en & r_done;
            // A core completion in the same cycle as a clear keeps DONE set
            if (core_done) begin
                r_done <= 1'b1;
            end else if (w_soft | w_w1c) begin
                r_done <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_irq_en <= w_wr_data[c_ctrl_irq_en];
            end
            if (w_wr_en) begin
                case (w_wr_idx[2:0])
                    c_reg_width: begin
                        if (w_wr_strb[0]) r_width[7:0]  <= w_wr_data[7:0];
                        if (w_wr_strb[1]) r_width[15:8] <= w_wr_data[15:8];
                    end
                    c_reg_height: begin
                        if (w_wr_strb[0]) r_height[7:0]  <= w_wr_data[7:0];
                        if (w_wr_strb[1]) r_height[15:8] <= w_wr_data[15:8];
                    end
                    c_reg_ksize: begin
                        if (w_wr_strb[0]) r_ksize <= ksize_e'(w_wr_data[1:0]);
                    end
                    c_reg_scratch: r_scratch <= apply_strb(r_scratch, w_wr_data, w_wr_strb);
                    default: ;
                endcase
            end
        end
    end

    assign S_AXI_AWREADY  = r_awready;
    assign S_AXI_WREADY   = r_wready;
    assign S_AXI_BVALID   = r_bvalid;
    assign S_AXI_BRESP    = r_bresp;
    assign S_AXI_ARREADY  = r_arready;
    assign S_AXI_RVALID   = r_rvalid;
    assign S_AXI_RRESP    = r_rresp;
    assign S_AXI_RDATA    = r_rdata;
    assign start_pulse    = r_start;
    assign soft_rst_pulse = r_soft_rst;
    assign img_width      = r_width;
    assign img_height     = r_height;
    assign ksize          = r_ksize;
    assign irq            = r_irq;

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, w_wr_addr[1:0], S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_median_filter_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_median_filter_axil_regs
//  Description : Directed self-checking bench for median_filter_axil_regs,
//                instantiated with a 6-bit address so out-of-range indices
//                can be exercised.
//  Revision    : 2.0 - typed register map with status, version and irq
// ============================================================================
module tb_median_filter_axil_regs;

    localparam logic [31:0] c_pix = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        start_pulse, soft_rst_pulse, irq;
    logic [15:0] img_width, img_height;
    logic [1:0]  ksize;
    logic        core_busy = 1'b0, core_done = 1'b0;
    logic [31:0] pix_cnt = c_pix;

    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int n_soft = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_pulse === 1'b1) n_start++;
        if (soft_rst_pulse === 1'b1) n_soft++;
    end

    median_filter_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6),
        .VERSION(32'h0002_0000)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .start_pulse(start_pulse), .soft_rst_pulse(soft_rst_pulse),
        .img_width(img_width), .img_height(img_height), .ksize(ksize), .irq(irq),
        .core_busy(core_busy), .core_done(core_done), .pix_cnt(pix_cnt)
    );

    // Bus driver: inputs change 1 time unit after the rising edge
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit aw_ok, w_ok, aw_hs, w_hs;
        int t;
        aw_ok = 0; w_ok = 0; t = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_ok && w_ok) && t < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin awvalid = 1'b0; aw_ok = 1; end
            if (w_hs)  begin wvalid  = 1'b0; w_ok  = 1; end
            t++;
        end
        while (bvalid !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        resp = bresp;
        n_cmp++;
        if (t >= 50) begin
            n_err++;
            $display("FAIL write_timeout addr=%h: no response within 50 cycles", a);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        int t;
        t = 0;
        araddr = a; arvalid = 1'b1;
        while (arready !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        while (rvalid !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        d = rdata; resp = rresp;
        n_cmp++;
        if (t >= 50) begin
            n_err++;
            $display("FAIL read_timeout addr=%h: no data within 50 cycles", a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_v [8];
        logic [31:0] d;
        logic [1:0]  r;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            n_err++; $display("FAIL reset_handshake got=%b want=00000", {awready, wready, bvalid, arready, rvalid});
        end
        n_cmp++;
        if ({bresp, rresp, rdata} !== 36'h0) begin
            n_err++; $display("FAIL reset_resp_data got=%h want=0", {bresp, rresp, rdata});
        end
        n_cmp++;
        if ({start_pulse, soft_rst_pulse, irq} !== 3'b0) begin
            n_err++; $display("FAIL reset_pulses got=%b want=000", {start_pulse, soft_rst_pulse, irq});
        end
        n_cmp++;
        if ({img_width, img_height, ksize} !== {16'd640, 16'd480, 2'd0}) begin
            n_err++; $display("FAIL reset_cfg_outputs got=%h/%h/%h want=280/1e0/0", img_width, img_height, ksize);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_v = '{32'h0, 32'h0, 32'h280, 32'h1E0, 32'h0, c_pix, 32'h0002_0000, 32'h0};
        for (int i = 0; i < 8; i++) begin
            axi_read(6'(i * 4), d, r);
            n_cmp++;
            if (d !== exp_v[i] || r !== 2'b00) begin
                n_err++; $display("FAIL reset_read reg%0d got=%h resp=%b want=%h resp=00", i, d, r, exp_v[i]);
            end
        end
    endtask

    task automatic test_strobe_order();
        logic [31:0] d;
        logic [1:0]  r;
        bready = 1'b0;
        wdata = 32'hDEAD_BEEF; wstrb = 4'b0101; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        n_cmp++;
        if (wready !== 1'b0 || bvalid !== 1'b0) begin
            n_err++; $display("FAIL w_first_hold wready=%b bvalid=%b want=0/0", wready, bvalid);
        end
        repeat (2) @(posedge clk);
        #1;
        awaddr = 6'h1C; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
                n_err++; $display("FAIL bvalid_hold cyc%0d bvalid=%b bresp=%b awready=%b wready=%b want=1/00/0/0",
                                  i, bvalid, bresp, awready, wready);
            end
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            n_err++; $display("FAIL b_release bvalid=%b awready=%b wready=%b want=0/1/1", bvalid, awready, wready);
        end
        axi_read(6'h1C, d, r);
        n_cmp++;
        if (d !== 32'h00AD_00EF) begin
            n_err++; $display("FAIL scratch_strobe got=%h want=00ad00ef", d);
        end
    endtask

    task automatic test_start();
        logic [31:0] d;
        logic [1:0]  r;
        int s0, f0;
        s0 = n_start;
        axi_write(6'h00, 32'h3, 4'hF, r);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (n_start - s0 !== 1) begin
            n_err++; $display("FAIL start_pulse_idle got=%0d cycles want=1", n_start - s0);
        end
        axi_read(6'h00, d, r);
        n_cmp++;
        if (d !== 32'h2) begin
            n_err++; $display("FAIL ctrl_readback got=%h want=2", d);
        end
        core_busy = 1'b1;
        s0 = n_start;
        axi_write(6'h00, 32'h3, 4'hF, r);
        repeat (2) @(posedge clk);
        #1;
        core_busy = 1'b0;
        n_cmp++;
        if (n_start - s0 !== 0) begin
            n_err++; $display("FAIL start_pulse_busy got=%0d cycles want=0", n_start - s0);
        end
        s0 = n_start; f0 = n_soft;
        axi_write(6'h00, 32'h7, 4'hF, r);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (n_start - s0 !== 0 || n_soft - f0 !== 1) begin
            n_err++; $display("FAIL start_and_soft start=%0d soft=%0d want=0/1", n_start - s0, n_soft - f0);
        end
    endtask

    task automatic test_done();
        logic [31:0] d;
        logic [1:0]  r;
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL irq_lag got=%b want=0", irq);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL irq_set got=%b want=1", irq);
        end
        axi_read(6'h04, d, r);
        n_cmp++;
        if (d !== 32'h2) begin
            n_err++; $display("FAIL status_done got=%h want=2", d);
        end
        // W1C update edge coincides with a second core_done
        n_cmp++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            n_err++; $display("FAIL ready_idle awready=%b wready=%b want=1/1", awready, wready);
        end
        awaddr = 6'h04; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; core_done = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; core_done = 1'b0;
        @(posedge clk); #1;
        axi_read(6'h04, d, r);
        n_cmp++;
        if (d !== 32'h2 || irq !== 1'b1) begin
            n_err++; $display("FAIL done_set_wins status=%h irq=%b want=2/1", d, irq);
        end
        awaddr = 6'h04; wdata = 32'h2; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL irq_w1c_lag got=%b want=1", irq);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL irq_w1c_clear got=%b want=0", irq);
        end
        axi_read(6'h04, d, r);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL status_w1c got=%h want=0", d);
        end
    endtask

    task automatic test_slverr();
        logic [31:0] d;
        logic [1:0]  r;
        int s0;
        s0 = n_start;
        axi_write(6'h20, 32'hFFFF_FFFF, 4'hF, r);
        n_cmp++;
        if (r !== 2'b10) begin
            n_err++; $display("FAIL wr_oor_20 resp got=%b want=10", r);
        end
        axi_write(6'h3C, 32'h1111_2222, 4'hF, r);
        n_cmp++;
        if (r !== 2'b10) begin
            n_err++; $display("FAIL wr_oor_3c resp got=%b want=10", r);
        end
        axi_read(6'h20, d, r);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b10) begin
            n_err++; $display("FAIL rd_oor_20 got=%h resp=%b want=0/10", d, r);
        end
        axi_read(6'h3C, d, r);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b10) begin
            n_err++; $display("FAIL rd_oor_3c got=%h resp=%b want=0/10", d, r);
        end
        axi_read(6'h1C, d, r);
        n_cmp++;
        if (d !== 32'h00AD_00EF) begin
            n_err++; $display("FAIL oor_scratch_kept got=%h want=00ad00ef", d);
        end
        axi_read(6'h00, d, r);
        n_cmp++;
        if (d !== 32'h2 || n_start != s0) begin
            n_err++; $display("FAIL oor_ctrl_kept ctrl=%h starts=%0d want=2/0", d, n_start - s0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        awaddr = 6'h08; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        n_cmp++;
        if (awready !== 1'b0 || wready !== 1'b1) begin
            n_err++; $display("FAIL aw_held awready=%b wready=%b want=0/1", awready, wready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            n_err++; $display("FAIL async_reset_abort got=%b want=00000", {awready, wready, bvalid, arready, rvalid});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        axi_read(6'h1C, d, r);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL scratch_after_reset got=%h want=0", d);
        end
        axi_write(6'h08, 32'h0000_0123, 4'hF, r);
        n_cmp++;
        if (r !== 2'b00) begin
            n_err++; $display("FAIL retry_write resp got=%b want=00", r);
        end
        axi_read(6'h08, d, r);
        n_cmp++;
        if (d !== 32'h123 || img_width !== 16'h0123) begin
            n_err++; $display("FAIL retry_width reg=%h out=%h want=123/0123", d, img_width);
        end
    endtask

    initial begin
        test_reset();
        test_strobe_order();
        test_start();
        test_done();
        test_slverr();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/median_filter_axil_regs.md
Name: median_filter_axil_regs

Overview:
- Next-generation AXI4-Lite control/status register slave for the median filter IP. It replaces the fixed 4-register, all-RW slave.
- Parametrised data and address width.
- Adds typed registers: self-clearing command bits, W1C sticky status, read-only core inputs, a version register and an interrupt output.
- Decodes out-of-range addresses with SLVERR.
- Sits between the block-design AXI interconnect and the median filter datapath core.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is legal, checked by elaboration assertion.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 2^(AW-2) word slots, minimum 5.
- VERSION, 32'h0002_0000, value returned by the VERSION register.

Ports:
- S_AXI_ACLK  in  1  sole clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  AW  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake
- S_AXI_BRESP  out  2  OKAY=00, SLVERR=10
- S_AXI_BVALID/S_AXI_BREADY  out/in  1  B handshake
- S_AXI_ARADDR  in  AW  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake
- start_pulse  out  1  one-cycle frame start to core
- soft_rst_pulse  out  1  one-cycle core soft reset
- img_width  out  16  frame width
- img_height  out  16  frame height
- ksize  out  2  0=3x3, 1=5x5, 2/3 reserved (stored)
- irq  out  1  level interrupt
- core_busy  in  1  core processing
- core_done  in  1  one-cycle frame-complete pulse
- pix_cnt  in  32  pixels output so far

Behaviour:
- Register map (word index):
  - 0 CTRL: bit0 START (W1 pulse, reads 0), bit1 IRQ_EN (RW), bit2 SOFT_RST (W1 pulse, reads 0).
  - 1 STATUS: bit0 BUSY (RO = core_busy), bit1 DONE (sticky, W1C).
  - 2 IMG_WIDTH [15:0] RW.
  - 3 IMG_HEIGHT [15:0] RW.
  - 4 KSIZE [1:0] RW.
  - 5 PIX_CNT RO.
  - 6 VERSION RO.
  - 7 SCRATCH [31:0] RW.
  - Unimplemented bits read 0. Index >=8 returns SLVERR, RDATA=0, no state change. Writes to RO registers return OKAY and are ignored.
- Reset values (all outputs): every READY/VALID=0, BRESP/RRESP=00, RDATA=0, pulses=0, irq=0. Registers: IMG_WIDTH=640, IMG_HEIGHT=480, KSIZE=0, SCRATCH=0, IRQ_EN=0, DONE=0.
- Write channel:
  - AW and W accepted independently, in either order. Each is captured into a holding register; its READY drops after capture until the write completes.
  - AWREADY=1 when no AW is held and BVALID=0. WREADY likewise for W.
  - Register update occurs in the cycle after both are held. BVALID rises in that same cycle and is held until BREADY; holds clear on the B handshake.
  - Minimum latency: AW+W in cycle N, register update and BVALID at N+1.
  - WSTRB applies per byte to RW registers. START/SOFT_RST/W1C act only if byte 0 strobe=1.
- Read channel:
  - ARREADY = !RVALID. AR handshake in cycle N gives RVALID/RDATA at N+1, held stable until RREADY.
  - Read data is sampled at N, so PIX_CNT/BUSY reflect cycle N.
- Pulses:
  - start_pulse is high exactly 1 cycle, at the update cycle.
  - START is ignored (no pulse) if core_busy=1 in the update cycle.
  - SOFT_RST pulses regardless of busy and also clears DONE.
  - START and SOFT_RST both set in one write: SOFT_RST only.
- DONE:
  - Set by core_done.
  - Simultaneous core_done and W1C in the same cycle: set wins (DONE=1).
- irq: registered IRQ_EN & DONE, i.e. one cycle after either changes.
- Reset mid-transaction: all handshakes abort, outputs return to reset values asynchronously. A master retry after reset completes normally.
- Simultaneous read and write to the same register: the read returns the pre-write value.

Decomposition:
- Package median_filter_regs_pkg:
  - register index localparams;
  - CTRL/STATUS bit positions;
  - RESP_OKAY/RESP_SLVERR;
  - reset value constants;
  - ksize_e enum.
- No sub-module. The AXI-Lite write-hold logic stays inline.

Test Plan:
- Reset, then read all 8 registers -> CTRL=0, STATUS=0, WIDTH=0x280, HEIGHT=0x1E0, KSIZE=0, PIX_CNT=pix_cnt, VERSION=0x00020000, SCRATCH=0; all OKAY.
- Write SCRATCH=0xDEADBEEF with WSTRB=0b0101, then W presented 3 cycles before AW -> read 0x00AD00EF. BVALID held 4 cycles under BREADY=0 with BRESP=00.
- Write CTRL=0x3 with core_busy=0 -> start_pulse high exactly 1 cycle, CTRL reads 0x2. Repeat with core_busy=1 -> no pulse.
- core_done pulse -> STATUS=0x2, irq=1. Write STATUS=0x2 in the same cycle as a second core_done -> DONE stays 1. A later W1C alone -> DONE=0, irq=0 next cycle.
- C_S_AXI_ADDR_WIDTH=6: read/write at 0x20 and 0x3C -> SLVERR, RDATA=0, no register changes.
- Assert ARESETN=0 while AW is held and W is pending -> all READY/VALID=0 immediately. After release, the repeated write completes with OKAY.
